rtype_pipe_datapath: RTL and testbench
======================================

Name: rtype_pipe_datapath

Overview:
- Parametrised two-stage successor to the single-cycle R-type DataPath.
- Accepts MIPS R-format instructions over a valid/ready handshake.
- Stage 1: decode, register-file read and ALU execute. Stage 2: write-back into the register file, plus exposure of the result on DS with a valid strobe and status flags.
- Handles read-after-write hazards between back-to-back instructions, either by forwarding or by stalling (see Optional Feature).

Parameters:
- XLEN, 32, datapath and register width in bits; legal range 8..64.
- REG_COUNT, 32, number of architectural registers; must be ≤32 because the encoding has 5-bit fields. Register 0 is hard-wired to zero.

Ports:
- CLK  in  1  clock; rising edge active.
- RST  in  1  reset; asynchronous, active-high.
- in_valid  in  1  instruction presented.
- in_ready  out  1  block can accept an instruction this cycle.
- instruction  in  32  R-format word: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- DS  out  XLEN  write-back result.
- ds_valid  out  1  DS, ds_rd and the flags are valid this cycle.
- ds_rd  out  5  destination register of the DS result.
- ovf  out  1  signed overflow on add/sub; qualified by ds_valid.
- illegal  out  1  unsupported opcode/funct; qualified by ds_valid.
- dbg_we  in  1  debug register-file write enable (preload).
- dbg_addr  in  5  debug write address.
- dbg_data  in  XLEN  debug write data.

Behaviour:
- Reset values: DS=0, ds_valid=0, ds_rd=0, ovf=0, illegal=0, in_ready=1, all registers 0, WB stage empty.
- Reset mid-operation discards any instruction in flight; no register write occurs.
- Accept: an instruction is accepted on a rising edge where in_valid && in_ready.
  - The ALU result is registered into the WB stage on that edge (edge k).
  - ds_valid=1 for exactly the one cycle after edge k, with DS, ds_rd, ovf and illegal.
  - The register file is written at edge k+1.
  - Latency is 1 cycle; throughput is 1 instruction per cycle when no stall occurs.
- Supported functions (op must be 0):
  - 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor
  - 0x2A slt (signed), 0x2B sltu
  - 0x00 sll, rt<<shamt; shamt is taken mod XLEN
- Arithmetic is modulo 2^XLEN. slt/sltu produce 0 or 1, zero-extended to XLEN.
- ovf: set only for add/sub on signed overflow. The result is still written back; addu/subu never set ovf.
- illegal: set for op≠0 or an unlisted funct. DS=0 and no register is written; ds_valid still pulses.
- Writes with rd=0 are discarded; register 0 always reads 0. Addresses ≥REG_COUNT read as 0 and are never written.
- A debug write commits at the edge where dbg_we=1. If WB writes the same address at the same edge, WB wins.
- Hazard: the stage-1 rs or rt equals the WB-stage rd, rd≠0, and the WB instruction is legal.

Optional Feature:
- Macro RTYPE_FWD_EN.
- Defined: the WB result is forwarded to the stage-1 operands. in_ready stays 1 permanently (outside reset) and there are no bubbles.
- Undefined: on a hazard, in_ready=0 for one cycle and the instruction is held. On the next cycle the register file holds the new value, and in_ready returns to 1.

Decomposition:
- Package rtype_pkg:
  - funct codes as localparams (F_ADD … F_SLL)
  - OP_RTYPE=6'd0
  - an alu_op_e enum
  - a decoded-instruction struct: rs, rt, rd, shamt, alu_op, illegal
- Sub-module rtype_alu: purely combinational; inputs a, b, shamt, alu_op; outputs y, ovf.
- The register file and hazard/forward logic stay in the top module.

Test Plan:
- Preload r1=5, r2=7 via debug port; add r4,r0,r1 (0x00012020) -> DS=5, ds_rd=4, ds_valid 1 cycle after accept.
- sub r5,r1,r2 (0x00222822) -> DS=0xFFFFFFFE, ovf=0. Then slt r6,r2,r3 with r3=0 -> DS=0.
- r1=0x7FFFFFFF; add r3,r1,r1 -> ovf=1, DS=0xFFFFFFFE written to r3. The same operands via addu -> ovf=0.
- Back-to-back add r4,r1,r2 then sub r5,r4,r1:
  - with RTYPE_FWD_EN -> in_ready stays 1 and DS=7;
  - without it -> one in_ready=0 cycle, then DS=7.
- Instruction 0x8C000000 (op≠0) and funct 0x3F -> illegal=1, DS=0, no register changes; rd=0 write -> r0 still 0.
- Assert RST the cycle after accept -> no ds_valid pulse, rd unchanged (0), in_ready=1 after release.

Source files
------------

// File: rtl/rtype_pkg.sv
// Shared encodings and decode for the pipelined R-type datapath.
// Defines funct codes, ALU operation enum and the decoded-instruction record.
package rtype_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_ADDU,
      ALU_SUB,
      ALU_SUBU,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLTU,
      ALU_SLL
   } alu_op_e;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      alu_op_e    alu_op;
      logic       illegal;
   } decoded_t;

   function automatic decoded_t decode(input logic [31:0] instr);
      decoded_t d;
      d.rs      = instr[25:21];
      d.rt      = instr[20:16];
      d.rd      = instr[15:11];
      d.shamt   = instr[10:6];
      d.alu_op  = ALU_ADD;
      d.illegal = 1'b0;
      case (instr[5:0])
         F_ADD:   d.alu_op = ALU_ADD;
         F_ADDU:  d.alu_op = ALU_ADDU;
         F_SUB:   d.alu_op = ALU_SUB;
         F_SUBU:  d.alu_op = ALU_SUBU;
         F_AND:   d.alu_op = ALU_AND;
         F_OR:    d.alu_op = ALU_OR;
         F_XOR:   d.alu_op = ALU_XOR;
         F_NOR:   d.alu_op = ALU_NOR;
         F_SLT:   d.alu_op = ALU_SLT;
         F_SLTU:  d.alu_op = ALU_SLTU;
         F_SLL:   d.alu_op = ALU_SLL;
         default: d.illegal = 1'b1;
      endcase
      if (instr[31:26] != OP_RTYPE) begin
         d.illegal = 1'b1;
      end
      return d;
   endfunction

endpackage

// File: rtl/rtype_alu.sv
// Combinational R-type ALU: modulo-2^XLEN arithmetic, logic, compares and sll.
// ovf is raised only for signed add/sub overflow.
module rtype_alu
   import rtype_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      shamt,
   input  alu_op_e         alu_op,
   output logic [XLEN-1:0] y,
   output logic            ovf
);

   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;
   logic [6:0]      sh_amt;
   logic            lt_s;
   logic            lt_u;

   assign sum    = a + b;
   assign diff   = a - b;
   // Shift distance wraps at the datapath width for narrow configurations.
   assign sh_amt = 7'(shamt) % 7'(XLEN);
   assign lt_s   = $signed(a) < $signed(b);
   assign lt_u   = a < b;

   always_comb begin
      y   = '0;
      ovf = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            y   = sum;
            ovf = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
         end
         ALU_ADDU: y = sum;
         ALU_SUB: begin
            y   = diff;
            ovf = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
         end
         ALU_SUBU: y = diff;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_NOR:  y = ~(a | b);
         ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
         ALU_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
         ALU_SLL:  y = b << sh_amt;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/rtype_pipe_datapath.sv
// Two-stage R-type datapath: decode/read/execute, then write-back with DS strobe.
// Define RTYPE_FWD_EN to forward WB results instead of stalling on RAW hazards.
module rtype_pipe_datapath
   import rtype_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction,
   output logic [XLEN-1:0] DS,
   output logic            ds_valid,
   output logic [4:0]      ds_rd,
   output logic            ovf,
   output logic            illegal,
   input  logic            dbg_we,
   input  logic [4:0]      dbg_addr,
   input  logic [XLEN-1:0] dbg_data
);

   localparam int         AW      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [5:0] REG_LIM = 6'(REG_COUNT);

   function automatic logic addr_ok(input logic [4:0] a);
      return (a != 5'd0) && ({1'b0, a} < REG_LIM);
   endfunction

   logic [XLEN-1:0] regs_q [REG_COUNT];

   logic            wb_valid_q,  wb_valid_d;
   logic [4:0]      wb_rd_q,     wb_rd_d;
   logic [XLEN-1:0] wb_result_q, wb_result_d;
   logic            wb_ovf_q,    wb_ovf_d;
   logic            wb_illegal_q, wb_illegal_d;

   decoded_t        dec;
   logic [XLEN-1:0] rf_rs, rf_rt;
   logic [XLEN-1:0] op_a, op_b;
   logic [XLEN-1:0] alu_y;
   logic            alu_ovf;
   logic            wb_we;
   logic            rs_hit, rt_hit;
   logic            accept;

   assign dec = decode(instruction);

   assign rf_rs = addr_ok(dec.rs) ? regs_q[dec.rs[AW-1:0]] : '0;
   assign rf_rt = addr_ok(dec.rt) ? regs_q[dec.rt[AW-1:0]] : '0;

   // A legal in-range WB instruction both commits next edge and defines the hazard window.
   assign wb_we  = wb_valid_q && !wb_illegal_q && addr_ok(wb_rd_q);
   assign rs_hit = wb_we && (dec.rs == wb_rd_q);
   assign rt_hit = wb_we && (dec.rt == wb_rd_q);

`ifdef RTYPE_FWD_EN
   assign op_a     = rs_hit ? wb_result_q : rf_rs;
   assign op_b     = rt_hit ? wb_result_q : rf_rt;
   assign in_ready = 1'b1;
`else
   assign op_a     = rf_rs;
   assign op_b     = rf_rt;
   assign in_ready = !(rs_hit || rt_hit);
`endif

   assign accept = in_valid && in_ready;

   rtype_alu #(
      .XLEN (XLEN)
   ) u_alu (
      .a      (op_a),
      .b      (op_b),
      .shamt  (dec.shamt),
      .alu_op (dec.alu_op),
      .y      (alu_y),
      .ovf    (alu_ovf)
   );

   always_comb begin
      wb_valid_d   = accept;
      wb_rd_d      = wb_rd_q;
      wb_result_d  = wb_result_q;
      wb_ovf_d     = wb_ovf_q;
      wb_illegal_d = wb_illegal_q;
      if (accept) begin
         wb_rd_d      = dec.rd;
         wb_result_d  = dec.illegal ? '0 : alu_y;
         wb_ovf_d     = !dec.illegal && alu_ovf;
         wb_illegal_d = dec.illegal;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wb_valid_q   <= 1'b0;
         wb_rd_q      <= '0;
         wb_result_q  <= '0;
         wb_ovf_q     <= 1'b0;
         wb_illegal_q <= 1'b0;
      end else begin
         wb_valid_q   <= wb_valid_d;
         wb_rd_q      <= wb_rd_d;
         wb_result_q  <= wb_result_d;
         wb_ovf_q     <= wb_ovf_d;
         wb_illegal_q <= wb_illegal_d;
      end
   end

   // Register 0 is a constant; WB takes priority over a same-edge debug write.
   for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               regs_q[gi] <= '0;
            end else begin
               regs_q[gi] <= '0;
            end
         end
      end else begin : g_reg
         logic wb_hit;
         logic dbg_hit;
         assign wb_hit  = wb_we && (wb_rd_q == 5'(gi));
         assign dbg_hit = dbg_we && (dbg_addr == 5'(gi));
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               regs_q[gi] <= '0;
            end else if (wb_hit) begin
               regs_q[gi] <= wb_result_q;
            end else if (dbg_hit) begin
               regs_q[gi] <= dbg_data;
            end
         end
      end
   end

   assign DS       = wb_result_q;
   assign ds_valid = wb_valid_q;
   assign ds_rd    = wb_rd_q;
   assign ovf      = wb_ovf_q;
   assign illegal  = wb_illegal_q;

endmodule

// File: tb/tb_rtype_pipe_datapath.sv
// Table-driven bench for rtype_pipe_datapath with an expected-result queue.
// Stall expectations follow RTYPE_FWD_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_rtype_pipe_datapath;
   import rtype_pkg::*;

   localparam int XLEN = 32;
`ifdef RTYPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [31:0]     instruction = '0;
   logic [XLEN-1:0] DS;
   logic            ds_valid;
   logic [4:0]      ds_rd;
   logic            ovf;
   logic            illegal;
   logic            dbg_we = 1'b0;
   logic [4:0]      dbg_addr = '0;
   logic [XLEN-1:0] dbg_data = '0;

   always #5 CLK = ~CLK;

   rtype_pipe_datapath #(
      .XLEN      (XLEN),
      .REG_COUNT (32)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .DS          (DS),
      .ds_valid    (ds_valid),
      .ds_rd       (ds_rd),
      .ovf         (ovf),
      .illegal     (illegal),
      .dbg_we      (dbg_we),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] ds;
      logic [4:0]  rd;
      logic        ovf;
      logic        ill;
      logic        haz;
   } vec_t;

   typedef struct {
      logic [31:0] ds;
      logic [4:0]  rd;
      logic        ovf;
      logic        ill;
      int          cyc;
      int          tag;
   } exp_t;

   vec_t vecs[26];
   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn);
      return {OP_RTYPE, rs, rt, rd, sh, fn};
   endfunction

   task automatic chk(input string nm, input int tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s tag=%0d got=%0h want=%0h", nm, tag, got, want);
      end
   endtask

   always @(negedge CLK) begin
      if (!RST && ds_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ds_valid got ds_rd=%0d DS=%0h want no pulse", ds_rd, DS);
         end else begin
            mon_e = exp_q.pop_front();
            $display("txn tag=%0d ds_rd=%0d DS=%08h ovf=%0b illegal=%0b", mon_e.tag, ds_rd, DS, ovf, illegal);
            chk("DS", mon_e.tag, DS, mon_e.ds);
            chk("ds_rd", mon_e.tag, ds_rd, mon_e.rd);
            chk("ovf", mon_e.tag, ovf, mon_e.ovf);
            chk("illegal", mon_e.tag, illegal, mon_e.ill);
            chk("latency", mon_e.tag, cyc, mon_e.cyc);
         end
      end
   end

   task automatic issue(input logic [31:0] ins, input logic [31:0] ds, input logic [4:0] rd,
                        input logic o, input logic il, input logic haz, input int tag, input bit push);
      int   waits;
      exp_t e;
      @(negedge CLK);
      dbg_we      = 1'b0;
      instruction = ins;
      in_valid    = 1'b1;
      #1;
      waits = 0;
      while (!in_ready && waits < 8) begin
         @(negedge CLK);
         #1;
         waits++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout tag=%0d got in_ready=0 want 1", tag);
      end else begin
         chk("stall_cycles", tag, waits, (haz && !FWD) ? 1 : 0);
         if (push) begin
            e.ds  = ds;
            e.rd  = rd;
            e.ovf = o;
            e.ill = il;
            e.cyc = cyc + 1;
            e.tag = tag;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic run_vec(input int i);
      issue(vecs[i].instr, vecs[i].ds, vecs[i].rd, vecs[i].ovf, vecs[i].ill, vecs[i].haz, i, 1'b1);
   endtask

   task automatic idle();
      @(negedge CLK);
      in_valid = 1'b0;
      dbg_we   = 1'b0;
   endtask

   task automatic dbg(input logic [4:0] a, input logic [31:0] d);
      @(negedge CLK);
      in_valid = 1'b0;
      dbg_we   = 1'b1;
      dbg_addr = a;
      dbg_data = d;
      @(negedge CLK);
      dbg_we   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // phase 1: r1=5, r2=7
      vecs[0]  = '{32'h00012020,                32'h00000005, 5'd4,  1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'h00222822,                32'hFFFFFFFE, 5'd5,  1'b0, 1'b0, 1'b0};
      vecs[2]  = '{mk(2, 3, 6, 0, F_SLT),       32'h00000000, 5'd6,  1'b0, 1'b0, 1'b0};
      vecs[3]  = '{mk(1, 2, 4, 0, F_ADD),       32'h0000000C, 5'd4,  1'b0, 1'b0, 1'b0};
      vecs[4]  = '{mk(4, 1, 5, 0, F_SUB),       32'h00000007, 5'd5,  1'b0, 1'b0, 1'b1};
      vecs[5]  = '{mk(5, 4, 7, 0, F_OR),        32'h0000000F, 5'd7,  1'b0, 1'b0, 1'b1};
      vecs[6]  = '{mk(4, 2, 8, 0, F_XOR),       32'h0000000B, 5'd8,  1'b0, 1'b0, 1'b0};
      vecs[7]  = '{mk(8, 0, 9, 0, F_NOR),       32'hFFFFFFF4, 5'd9,  1'b0, 1'b0, 1'b1};
      vecs[8]  = '{mk(1, 9, 10, 0, F_SLTU),     32'h00000001, 5'd10, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{mk(9, 1, 11, 0, F_SLT),      32'h00000001, 5'd11, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{mk(0, 2, 12, 4, F_SLL),      32'h00000070, 5'd12, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{mk(0, 1, 13, 31, F_SLL),     32'h80000000, 5'd13, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{mk(1, 2, 14, 0, F_ADDU),     32'h0000000C, 5'd14, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{mk(1, 2, 15, 0, F_SUBU),     32'hFFFFFFFE, 5'd15, 1'b0, 1'b0, 1'b0};
      // phase 2: r1=0x7FFFFFFF
      vecs[14] = '{mk(1, 1, 3, 0, F_ADD),       32'hFFFFFFFE, 5'd3,  1'b1, 1'b0, 1'b0};
      vecs[15] = '{mk(1, 1, 16, 0, F_ADDU),     32'hFFFFFFFE, 5'd16, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{mk(3, 0, 17, 0, F_ADD),      32'hFFFFFFFE, 5'd17, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{mk(0, 1, 18, 0, F_SUB),      32'h80000001, 5'd18, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{mk(1, 13, 19, 0, F_SUB),     32'hFFFFFFFF, 5'd19, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{mk(13, 13, 20, 0, F_ADD),    32'h00000000, 5'd20, 1'b1, 1'b0, 1'b0};
      vecs[20] = '{32'h8C000000,                32'h00000000, 5'd0,  1'b0, 1'b1, 1'b0};
      vecs[21] = '{mk(1, 2, 4, 0, 6'h3F),       32'h00000000, 5'd4,  1'b0, 1'b1, 1'b0};
      vecs[22] = '{mk(4, 0, 21, 0, F_ADD),      32'h0000000C, 5'd21, 1'b0, 1'b0, 1'b0};
      vecs[23] = '{mk(1, 1, 0, 0, F_ADD),       32'hFFFFFFFE, 5'd0,  1'b1, 1'b0, 1'b0};
      vecs[24] = '{mk(0, 1, 22, 0, F_ADD),      32'h7FFFFFFF, 5'd22, 1'b0, 1'b0, 1'b0};
      vecs[25] = '{mk(0, 0, 23, 0, F_OR),       32'h00000000, 5'd23, 1'b0, 1'b0, 1'b0};

      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("reset_DS", -1, DS, 0);
      chk("reset_ds_valid", -1, ds_valid, 0);
      chk("reset_ds_rd", -1, ds_rd, 0);
      chk("reset_ovf", -1, ovf, 0);
      chk("reset_illegal", -1, illegal, 0);
      chk("reset_in_ready", -1, in_ready, 1);

      dbg(5'd1, 32'd5);
      dbg(5'd2, 32'd7);
      for (int i = 0; i < 14; i++) run_vec(i);
      dbg(5'd1, 32'h7FFFFFFF);
      for (int i = 14; i < 26; i++) run_vec(i);

      // WB and debug port write r24 at the same edge: WB value must survive
      issue(mk(1, 0, 24, 0, F_ADD), 32'h7FFFFFFF, 5'd24, 1'b0, 1'b0, 1'b0, 80, 1'b1);
      @(negedge CLK);
      in_valid = 1'b0;
      dbg_we   = 1'b1;
      dbg_addr = 5'd24;
      dbg_data = 32'hDEADBEEF;
      issue(mk(24, 0, 25, 0, F_OR), 32'h7FFFFFFF, 5'd25, 1'b0, 1'b0, 1'b0, 81, 1'b1);
      dbg(5'd30, 32'h12345678);
      issue(mk(30, 0, 31, 0, F_OR), 32'h12345678, 5'd31, 1'b0, 1'b0, 1'b0, 82, 1'b1);

      // reset right after accept: in-flight result must vanish
      issue(mk(1, 2, 27, 0, F_ADD), 32'h0, 5'd27, 1'b0, 1'b0, 1'b0, 90, 1'b0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(negedge CLK);
      in_valid = 1'b0;
      chk("rst_mid_ds_valid", 90, ds_valid, 0);
      chk("rst_mid_in_ready", 90, in_ready, 1);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("post_rst_in_ready", 91, in_ready, 1);
      chk("post_rst_DS", 91, DS, 0);
      issue(mk(27, 0, 28, 0, F_ADD), 32'h0, 5'd28, 1'b0, 1'b0, 1'b0, 92, 1'b1);
      issue(mk(4, 2, 29, 0, F_ADD), 32'h0, 5'd29, 1'b0, 1'b0, 1'b0, 93, 1'b1);
      idle();
      repeat (4) @(negedge CLK);
      chk("queue_drained", 99, exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
